wb_write_arbiter: RTL and testbench

//   Writer side of the register-file write port (RegWrite/wr_addr/wr_data).

---
 rtl/wb_write_arbiter_pkg.sv | 32 +++
 rtl/wb_write_arbiter_if.sv | 39 +++
 rtl/wb_write_arbiter_fifo.sv | 72 +++++++
 rtl/wb_write_arbiter.sv | 106 ++++++++++
 tb/tb_wb_write_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// Shared types and sizing for the register-file write arbiter.
// Holds the writeback entry layout, the arbitration select and a busy-mask helper.
package wb_write_arbiter_pkg;

  localparam int unsigned Xlen      = 32;
  localparam int unsigned RegAw     = 5;
  localparam int unsigned NumRegs   = 1 << RegAw;
  localparam int unsigned FifoDepth = 4;
  localparam int unsigned CountW    = $clog2(FifoDepth) + 1;

  typedef struct packed {
    logic [RegAw-1:0] addr;
    logic [Xlen-1:0]  data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SelNone,
    SelPipe,
    SelLong
  } wb_sel_e;

  // One-hot register mask; x0 never appears in the scoreboard.
  function automatic logic [NumRegs-1:0] reg_bit(input logic [RegAw-1:0] addr);
    logic [NumRegs-1:0] mask;
    mask = '0;
    if (addr != '0) begin
      mask[addr] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/wb_write_arbiter_if.sv
// Bundle of result streams, long-unit handshake, RF write port and scoreboard view.
// The slave modport is the arbiter; the master modport is whoever drives the results.
interface wb_write_arbiter_if;
  import wb_write_arbiter_pkg::*;

  logic               pipe_valid;
  logic [RegAw-1:0]   pipe_addr;
  logic [Xlen-1:0]    pipe_data;
  logic               iss_valid;
  logic [RegAw-1:0]   iss_addr;
  logic               lng_valid;
  logic               lng_ready;
  logic [RegAw-1:0]   lng_addr;
  logic [Xlen-1:0]    lng_data;
  logic               reg_write;
  logic [RegAw-1:0]   wr_addr;
  logic [Xlen-1:0]    wr_data;
  logic [NumRegs-1:0] busy;
  logic [CountW-1:0]  fifo_count;

  modport slave (
    input  pipe_valid, pipe_addr, pipe_data,
    input  iss_valid, iss_addr,
    input  lng_valid, lng_addr, lng_data,
    output lng_ready,
    output reg_write, wr_addr, wr_data,
    output busy, fifo_count
  );

  modport master (
    output pipe_valid, pipe_addr, pipe_data,
    output iss_valid, iss_addr,
    output lng_valid, lng_addr, lng_data,
    input  lng_ready,
    input  reg_write, wr_addr, wr_data,
    input  busy, fifo_count
  );

endinterface

// File: rtl/wb_write_arbiter_fifo.sv
// Synchronous FIFO of writeback entries with occupancy count.
// Push is refused when full and pop is ignored when empty, both judged on start-of-cycle state.
module wb_write_arbiter_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  wb_entry_t                  entry_i,
  input  logic                       pop_i,
  output wb_entry_t                  entry_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  wb_entry_t            mem_q [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  logic                 push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign entry_o = mem_q[rd_ptr_q];

  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed through a valid count.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= entry_i;
    end
  end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges in-order pipeline writeback and queued long-latency results onto the single
// register-file write port, and tracks destinations of in-flight long ops for decode stalls.
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
(
  input logic              clk_i,
  input logic              rst_ni,
  wb_write_arbiter_if.slave wb_io
);

  wb_entry_t          push_entry;
  wb_entry_t          head;
  logic               fifo_full;
  logic               fifo_empty;
  logic [CountW-1:0]  fifo_count;
  logic               push;
  logic               pop;
  logic               pipe_win;
  wb_sel_e            sel;

  logic               reg_write_q, reg_write_d;
  logic [RegAw-1:0]   wr_addr_q, wr_addr_d;
  logic [Xlen-1:0]    wr_data_q, wr_data_d;
  logic [NumRegs-1:0] busy_q, busy_d;

  // Held low during reset so nothing is handed over to a FIFO that is being cleared.
  assign wb_io.lng_ready = !fifo_full && rst_ni;

  assign push             = wb_io.lng_valid && wb_io.lng_ready;
  assign push_entry.addr  = wb_io.lng_addr;
  assign push_entry.data  = wb_io.lng_data;
  assign pipe_win         = wb_io.pipe_valid && (wb_io.pipe_addr != '0);
  assign pop              = (sel == SelLong);

  wb_write_arbiter_fifo #(
    .Depth (FifoDepth)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .entry_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    sel = SelNone;
    if (pipe_win) begin
      sel = SelPipe;
    end else if (!fifo_empty) begin
      sel = SelLong;
    end
  end

  always_comb begin
    reg_write_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    busy_d      = busy_q;
    unique case (sel)
      SelPipe: begin
        reg_write_d = 1'b1;
        wr_addr_d   = wb_io.pipe_addr;
        wr_data_d   = wb_io.pipe_data;
      end
      SelLong: begin
        // An entry for x0 is drained without touching the write port.
        if (head.addr != '0) begin
          reg_write_d = 1'b1;
          wr_addr_d   = head.addr;
          wr_data_d   = head.data;
        end
        busy_d = busy_q & ~reg_bit(head.addr);
      end
      default: ;
    endcase
    // Applied after the clear so a same-register reissue stays pending.
    if (wb_io.iss_valid) begin
      busy_d = busy_d | reg_bit(wb_io.iss_addr);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_write_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      busy_q      <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
    end
  end

  assign wb_io.reg_write  = reg_write_q;
  assign wb_io.wr_addr    = wr_addr_q;
  assign wb_io.wr_data    = wr_data_q;
  assign wb_io.busy       = busy_q;
  assign wb_io.fifo_count = fifo_count;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;

  logic clk;
  logic rst_n;

  wb_write_arbiter_if wb ();

  wb_write_arbiter dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .wb_io  (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model state
  wb_entry_t          m_q[$];
  logic [NumRegs-1:0] m_busy;
  logic               m_we;
  logic [RegAw-1:0]   m_addr;
  logic [Xlen-1:0]    m_data;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_busy = '0;
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic check_all();
    int unsigned sz;
    sz = m_q.size();
    chk("reg_write",  64'(wb.reg_write),  64'(m_we));
    chk("wr_addr",    64'(wb.wr_addr),    64'(m_addr));
    chk("wr_data",    64'(wb.wr_data),    64'(m_data));
    chk("busy",       64'(wb.busy),       64'(m_busy));
    chk("fifo_count", 64'(wb.fifo_count), 64'(sz));
    chk("lng_ready",  64'(wb.lng_ready),  64'(rst_n && (sz < FifoDepth)));
  endtask

  task automatic idle();
    wb.pipe_valid = 1'b0;
    wb.pipe_addr  = '0;
    wb.pipe_data  = '0;
    wb.iss_valid  = 1'b0;
    wb.iss_addr   = '0;
    wb.lng_valid  = 1'b0;
    wb.lng_addr   = '0;
    wb.lng_data   = '0;
  endtask

  // Advance one clock: decide from start-of-cycle state, commit at the edge, check after it.
  task automatic cycle();
    bit        win, pop, push;
    wb_entry_t h, e;
    push   = rst_n && wb.lng_valid && (m_q.size() < FifoDepth);
    win    = wb.pipe_valid && (wb.pipe_addr != 0);
    pop    = !win && (m_q.size() > 0);
    e.addr = wb.lng_addr;
    e.data = wb.lng_data;
    @(posedge clk);
    if (rst_n) begin
      m_we = 1'b0;
      if (win) begin
        m_we   = 1'b1;
        m_addr = wb.pipe_addr;
        m_data = wb.pipe_data;
      end else if (pop) begin
        h = m_q.pop_front();
        if (h.addr != 0) begin
          m_we   = 1'b1;
          m_addr = h.addr;
          m_data = h.data;
        end
        m_busy[h.addr] = 1'b0;
      end
      if (push) m_q.push_back(e);
      if (wb.iss_valid && wb.iss_addr != 0) m_busy[wb.iss_addr] = 1'b1;
      m_busy[0] = 1'b0;
    end
    #1;
    check_all();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("rst_reg_write", 64'(wb.reg_write), 64'd0);
    rst_n = 1'b1;
    cycle();

    // Pipe only: one-cycle latency, then idle
    wb.pipe_valid = 1'b1; wb.pipe_addr = 5'd7; wb.pipe_data = 32'hDEADBEEF;
    cycle();
    chk("pipe_we",   64'(wb.reg_write), 64'd1);
    chk("pipe_addr", 64'(wb.wr_addr),   64'd7);
    chk("pipe_data", 64'(wb.wr_data),   64'hDEADBEEF);
    idle();
    cycle();
    chk("pipe_we_off",   64'(wb.reg_write), 64'd0);
    chk("pipe_hold_dat", 64'(wb.wr_data),   64'hDEADBEEF);

    // Reset mid-operation: three entries queued behind a busy pipeline
    wb.pipe_valid = 1'b1; wb.pipe_addr = 5'd9; wb.pipe_data = 32'h1;
    wb.iss_valid  = 1'b1; wb.iss_addr  = 5'd5;
    for (int i = 0; i < 3; i++) begin
      wb.lng_valid = 1'b1; wb.lng_addr = 5'(10 + i); wb.lng_data = 32'(32'hA0 + i);
      cycle();
      wb.iss_valid = 1'b0;
    end
    chk("pre_rst_count", 64'(wb.fifo_count), 64'd3);
    chk("pre_rst_busy5", 64'(wb.busy[5]),    64'd1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_we",    64'(wb.reg_write),  64'd0);
    chk("async_count", 64'(wb.fifo_count), 64'd0);
    chk("async_busy",  64'(wb.busy),       64'd0);
    chk("async_ready", 64'(wb.lng_ready),  64'd0);
    idle();
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("no_stale_we", 64'(wb.reg_write), 64'd0);
    end

    // Priority: queued {3,0x11} waits behind two pipe writes to 4
    wb.iss_valid = 1'b1; wb.iss_addr = 5'd3;
    cycle();
    idle();
    wb.lng_valid = 1'b1; wb.lng_addr = 5'd3; wb.lng_data = 32'h11;
    cycle();
    idle();
    wb.pipe_valid = 1'b1; wb.pipe_addr = 5'd4; wb.pipe_data = 32'h22;
    cycle();
    chk("prio_w1", 64'(wb.wr_addr), 64'd4);
    cycle();
    chk("prio_w2", 64'(wb.wr_addr), 64'd4);
    chk("prio_busy3_held", 64'(wb.busy[3]), 64'd1);
    idle();
    cycle();
    chk("prio_w3_we",   64'(wb.reg_write), 64'd1);
    chk("prio_w3_addr", 64'(wb.wr_addr),   64'd3);
    chk("prio_w3_data", 64'(wb.wr_data),   64'h11);
    chk("prio_busy3",   64'(wb.busy[3]),   64'd0);

    // Full FIFO: fill while the pipeline blocks pops, then offer during a pop
    wb.pipe_valid = 1'b1; wb.pipe_addr = 5'd9; wb.pipe_data = 32'h99;
    for (int i = 0; i < 4; i++) begin
      wb.lng_valid = 1'b1; wb.lng_addr = 5'(12 + i); wb.lng_data = 32'(32'hC0 + i);
      cycle();
    end
    chk("full_count", 64'(wb.fifo_count), 64'd4);
    chk("full_ready", 64'(wb.lng_ready),  64'd0);
    wb.pipe_valid = 1'b0;
    wb.lng_addr = 5'd17; wb.lng_data = 32'hBAD;
    cycle();
    chk("full_refuse_count", 64'(wb.fifo_count), 64'd3);
    chk("full_pop_addr",     64'(wb.wr_addr),    64'd12);
    idle();
    repeat (3) cycle();
    chk("drain_last_addr", 64'(wb.wr_addr),    64'd15);
    chk("drain_count",     64'(wb.fifo_count), 64'd0);
    cycle();
    chk("drain_no_17", 64'(wb.reg_write), 64'd0);

    // Scoreboard race: pop to 6 while 6 is reissued
    wb.iss_valid = 1'b1; wb.iss_addr = 5'd6;
    cycle();
    idle();
    wb.lng_valid = 1'b1; wb.lng_addr = 5'd6; wb.lng_data = 32'h66;
    cycle();
    idle();
    wb.iss_valid = 1'b1; wb.iss_addr = 5'd6;
    cycle();
    chk("race_we",    64'(wb.wr_addr), 64'd6);
    chk("race_busy6", 64'(wb.busy[6]), 64'd1);
    idle();
    cycle();

    // x0: pipe and long writes to register 0 are dropped; long entry still drains
    wb.pipe_valid = 1'b1; wb.pipe_addr = 5'd0; wb.pipe_data = 32'h55;
    wb.lng_valid  = 1'b1; wb.lng_addr  = 5'd0; wb.lng_data  = 32'h77;
    cycle();
    chk("x0_pipe_we", 64'(wb.reg_write),  64'd0);
    chk("x0_count1",  64'(wb.fifo_count), 64'd1);
    wb.lng_valid = 1'b0;
    wb.iss_valid = 1'b1; wb.iss_addr = 5'd0;
    cycle();
    chk("x0_lng_we", 64'(wb.reg_write),  64'd0);
    chk("x0_count0", 64'(wb.fifo_count), 64'd0);
    chk("x0_busy0",  64'(wb.busy[0]),    64'd0);
    idle();
    repeat (2) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
